// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// word and latency-counter widths, and the byte-lane merge helper.
package dmem_pkg;

    localparam int DMEM_WORD_W = 32;
    localparam int DMEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Replace each byte lane of old_word whose enable bit is set with the
    // matching lane of new_word; lane i occupies bits 8i+7:8i.
    function automatic logic [DMEM_WORD_W-1:0] merge_bytes(
        input logic [DMEM_WORD_W-1:0] old_word,
        input logic [DMEM_WORD_W-1:0] new_word,
        input logic [3:0]             be
    );
        logic [DMEM_WORD_W-1:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Backing store for the responder: single-port word array with a
// synchronous write and a registered (read-first) read. Not reset, so the
// contents survive a responder reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic                           we,
    input  logic [DMEM_WORD_W-1:0]         wdata,
    output logic [DMEM_WORD_W-1:0]         rdata
);

    logic [DMEM_WORD_W-1:0] mem [DEPTH_WORDS];
    logic [DMEM_WORD_W-1:0] rdata_q;

    // Write the addressed word when enabled and register the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency memory responder for a cache: accepts one request at a time,
// performs the access LATENCY edges after accept and holds the response until
// the cache takes it. Define DMEM_BYTE_EN_EN to add the req_be byte-enable
// input; without it every write replaces the whole word.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [31:0]            req_addr,
    input  logic [DMEM_WORD_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
    input  logic [3:0]             req_be,
`endif
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DMEM_WORD_W-1:0] rsp_rdata,
    output logic                   rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_CNT_W-1:0] LAT_LOAD = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_e            state_q, state_d;
    logic [DMEM_CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic                   we_q, we_d;
    logic                   err_q, err_d;
    logic [DMEM_WORD_W-1:0] wdata_q, wdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DMEM_WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [3:0]             be_cur;

`ifdef DMEM_BYTE_EN_EN
    logic [3:0] be_q, be_d;
    assign be_cur = be_q;
`else
    assign be_cur = 4'hF;
`endif

    logic                   req_err;
    logic                   access;
    logic [AW-1:0]          arr_addr;
    logic                   arr_we;
    logic [DMEM_WORD_W-1:0] arr_rdata;
    logic [DMEM_WORD_W-1:0] merged;

    // Misaligned byte address or any address bit above the word index range.
    assign req_err  = (|req_addr[1:0]) | (|(req_addr >> (AW + 2)));
    assign access   = (state_q == ST_WAIT) && (cnt_q == '0);
    // While idle the array pre-reads the incoming address so the old word is
    // already registered by the access edge, even for LATENCY=1.
    assign arr_addr = (state_q == ST_IDLE) ? req_addr[AW+1:2] : idx_q;
    assign arr_we   = access && we_q && !err_q;
    assign merged   = merge_bytes(arr_rdata, wdata_q, be_cur);

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .addr  (arr_addr),
        .we    (arr_we),
        .wdata (merged),
        .rdata (arr_rdata)
    );

    // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        we_d        = we_q;
        err_d       = err_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef DMEM_BYTE_EN_EN
        be_d        = be_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    idx_d   = req_addr[AW+1:2];
                    we_d    = req_we;
                    err_d   = req_err;
                    wdata_d = req_wdata;
`ifdef DMEM_BYTE_EN_EN
                    be_d    = req_be;
`endif
                    cnt_d   = LAT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    if (err_q) begin
                        rsp_rdata_d = '0;
                    end else if (we_q) begin
                        rsp_rdata_d = merged;
                    end else begin
                        rsp_rdata_d = arr_rdata;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register the FSM, captured request and response; reset aborts any request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef DMEM_BYTE_EN_EN
            be_q        <= 4'h0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            err_q       <= err_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef DMEM_BYTE_EN_EN
            be_q        <= be_d;
`endif
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
